// File: rtl/vga_scanout_if.sv
// Signal bundle between the VGA scan-out block, the upstream renderers and the board pins.
// The master side is the scan-out block. The slave side covers the renderers and the pins.
interface vga_scanout_if;
  logic [9:0] o_Col;
  logic [9:0] o_Row;
  logic       o_Active;
  logic [4:0] o_Tile_X;
  logic [3:0] o_Tile_Y;
  logic [4:0] o_Local_X;
  logic [4:0] o_Local_Y;
  logic       o_Frame_Start;
  logic [8:0] i_Pixel;
  logic       o_VGA_HSync;
  logic       o_VGA_VSync;
  logic [2:0] o_VGA_Red;
  logic [2:0] o_VGA_Grn;
  logic [2:0] o_VGA_Blu;

  modport master (
    output o_Col, o_Row, o_Active, o_Tile_X, o_Tile_Y, o_Local_X, o_Local_Y,
    output o_Frame_Start, o_VGA_HSync, o_VGA_VSync, o_VGA_Red, o_VGA_Grn, o_VGA_Blu,
    input  i_Pixel
  );

  modport slave (
    input  o_Col, o_Row, o_Active, o_Tile_X, o_Tile_Y, o_Local_X, o_Local_Y,
    input  o_Frame_Start, o_VGA_HSync, o_VGA_VSync, o_VGA_Red, o_VGA_Grn, o_VGA_Blu,
    output i_Pixel
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA scan-out back-end.
// The block free-runs the 640x480@60 raster counters and publishes the current coordinate,
// both raw and split into tile and offset fields.
// Sync and blanking are delayed through a PIXEL_LATENCY-deep line so that they meet the
// renderer's pixel at the output register.
// PIXEL_LATENCY must be in the range 1..4.
module vga_scanout #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  vga_scanout_if.master  bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // The delay-line word is {active, hsync, vsync}. The idle word is blanked, with both syncs released.
  localparam logic [2:0] DLY_IDLE   = 3'b011;

  logic [9:0] col_r;
  logic [9:0] row_r;
  logic       col_wrap_s;
  logic       row_wrap_s;
  logic       active_s;
  logic       hsync_raw_s;
  logic       vsync_raw_s;
  logic [2:0] dly_r [PIXEL_LATENCY];
  logic [2:0] tap_s;
  logic       hsync_r;
  logic       vsync_r;
  logic [8:0] rgb_r;

  assign col_wrap_s = (col_r == H_LAST);
  assign row_wrap_s = (row_r == V_LAST);

  // Raster counters: the column advances every clock, and the row advances on column wrap.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      col_r <= 10'd0;
      row_r <= 10'd0;
    end else begin
      if (col_wrap_s) begin
        col_r <= 10'd0;
        if (row_wrap_s) begin
          row_r <= 10'd0;
        end else begin
          row_r <= row_r + 10'd1;
        end
      end else begin
        col_r <= col_r + 10'd1;
      end
    end
  end

  // Undelayed visibility and active-low sync windows derived from the counters.
  always_comb begin
    active_s    = 1'b0;
    hsync_raw_s = 1'b1;
    vsync_raw_s = 1'b1;
    if ((col_r < H_VIS) && (row_r < V_VIS)) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end
    if ((col_r >= HS_FIRST) && (col_r <= HS_LAST)) begin
      hsync_raw_s = 1'b0;
    end else begin
      hsync_raw_s = 1'b1;
    end
    if ((row_r >= VS_FIRST) && (row_r <= VS_LAST)) begin
      vsync_raw_s = 1'b0;
    end else begin
      vsync_raw_s = 1'b1;
    end
  end

  // The alignment shift register holds the timing bits while the renderer computes the pixel.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < PIXEL_LATENCY; i++) begin
        dly_r[i] <= DLY_IDLE;
      end
    end else begin
      dly_r[0] <= {active_s, hsync_raw_s, vsync_raw_s};
      for (int i = 1; i < PIXEL_LATENCY; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

  assign tap_s = dly_r[PIXEL_LATENCY-1];

  // Pin register: captures the delayed timing bits with the renderer pixel, and blanks outside the visible area.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      rgb_r   <= 9'd0;
    end else begin
      hsync_r <= tap_s[1];
      vsync_r <= tap_s[0];
      rgb_r   <= tap_s[2] ? bus.i_Pixel : 9'd0;
    end
  end

  // The coordinate group is wired straight from the counter registers, so it adds no latency.
  assign bus.o_Col         = col_r;
  assign bus.o_Row         = row_r;
  assign bus.o_Active      = active_s;
  assign bus.o_Tile_X      = col_r[9:5];
  assign bus.o_Tile_Y      = row_r[8:5];
  assign bus.o_Local_X     = col_r[4:0];
  assign bus.o_Local_Y     = row_r[4:0];
  assign bus.o_Frame_Start = (col_r == 10'd0) && (row_r == 10'd0) && !i_Rst;

  assign bus.o_VGA_HSync   = hsync_r;
  assign bus.o_VGA_VSync   = vsync_r;
  assign bus.o_VGA_Red     = rgb_r[8:6];
  assign bus.o_VGA_Grn     = rgb_r[5:3];
  assign bus.o_VGA_Blu     = rgb_r[2:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout.
// DUT A uses the standard 640x480 timing with latency 1. It drives a column-echo pixel and
// receives a one-clock reset in the middle of a line.
// DUT B keeps the standard horizontal timing but uses a short vertical frame and latency 3.
// This exercises vsync and the frame period within a short run.
module tb_vga_scanout;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  vga_scanout_if if_a ();
  vga_scanout_if if_b ();

  vga_scanout dut_a (.i_Clk(clk), .i_Rst(rst_a), .bus(if_a));

  vga_scanout #(
    .V_VISIBLE(20), .V_FRONT(3), .V_SYNC(2), .V_BACK(4), .PIXEL_LATENCY(3)
  ) dut_b (.i_Clk(clk), .i_Rst(rst_b), .bus(if_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int t_a = 0;
  int t_b = 0;
  bit started_a = 1'b0;
  bit started_b = 1'b0;
  bit rst_q_a = 1'b0;
  bit rst_q_b = 1'b0;
  logic [8:0] prev_a = 9'd0;
  logic [8:0] prev_b = 9'd0;

  int hs_cnt_a = 0, hs_first_a = -1;
  int vs_cnt_b = 0, vs_first_b = -1;
  int fs_cnt_b = 0, fs_last_b = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the pins: the timing comes from the coordinate L+1 cycles earlier, and the colour
  // is the pixel held during the previous cycle.
  function automatic void exp_pins(input int t, input int lat, input int vvis, input int vs_lo,
                                   input int vs_hi, input int vtot, input logic [8:0] prev,
                                   output logic hs, output logic vs, output logic [8:0] rgb);
    int n, c, r;
    if (t <= lat) begin
      hs = 1'b1; vs = 1'b1; rgb = 9'd0;
    end else begin
      n = t - lat - 1;
      c = n % 800;
      r = (n / 800) % vtot;
      hs  = !(c >= 656 && c <= 751);
      vs  = !(r >= vs_lo && r <= vs_hi);
      rgb = (c < 640 && r < vvis) ? prev : 9'd0;
    end
  endfunction

  task automatic check_dut(input string tag, input int t, input int lat, input int vvis,
                           input int vs_lo, input int vs_hi, input int vtot, input logic [8:0] prev,
                           input logic [9:0] col, input logic [9:0] row, input logic act,
                           input logic [4:0] tx, input logic [3:0] ty, input logic [4:0] lx,
                           input logic [4:0] ly, input logic fs, input logic hs, input logic vs,
                           input logic [8:0] rgb);
    int c, r;
    logic e_act, e_hs, e_vs;
    logic [8:0] e_rgb;
    c = t % 800;
    r = (t / 800) % vtot;
    e_act = (c < 640) && (r < vvis);
    chk({tag, "_col"}, 32'(col), 32'(c));
    chk({tag, "_row"}, 32'(row), 32'(r));
    chk({tag, "_active"}, 32'(act), 32'(e_act));
    chk({tag, "_frame_start"}, 32'(fs), 32'((c == 0) && (r == 0)));
    if (e_act) begin
      chk({tag, "_tile_x"}, 32'(tx), 32'(c / 32));
      chk({tag, "_tile_y"}, 32'(ty), 32'(r / 32));
      chk({tag, "_local_x"}, 32'(lx), 32'(c % 32));
      chk({tag, "_local_y"}, 32'(ly), 32'(r % 32));
    end
    exp_pins(t, lat, vvis, vs_lo, vs_hi, vtot, prev, e_hs, e_vs, e_rgb);
    chk({tag, "_hsync"}, 32'(hs), 32'(e_hs));
    chk({tag, "_vsync"}, 32'(vs), 32'(e_vs));
    chk({tag, "_rgb"}, 32'(rgb), 32'(e_rgb));
  endtask

  // Cycle index since the last reset, for each DUT. It is updated on the active edge.
  initial begin
    forever begin
      @(posedge clk);
      rst_q_a = rst_a;
      rst_q_b = rst_b;
      if (rst_a) begin t_a = 0; started_a = 1'b1; end else t_a++;
      if (rst_b) begin t_b = 0; started_b = 1'b1; end else t_b++;
    end
  end

  // Renderer stand-in for A. It echoes the previous column and outputs white during the row-1 blanking.
  initial begin
    int pt, pc, pr;
    if_a.i_Pixel = 9'd0;
    forever begin
      @(posedge clk);
      #1;
      pt = t_a + 419999;
      pc = pt % 800;
      pr = (pt / 800) % 525;
      if (pr == 1 && pc >= 640) if_a.i_Pixel = 9'h1FF;
      else if_a.i_Pixel = 9'(pc % 512);
    end
  end

  // Renderer stand-in for B. It outputs a pattern in the visible rows and white in the vertical blanking.
  initial begin
    int r;
    if_b.i_Pixel = 9'd0;
    forever begin
      @(posedge clk);
      #1;
      r = (t_b / 800) % 29;
      if (r >= 20) if_b.i_Pixel = 9'h1FF;
      else if_b.i_Pixel = 9'((t_b * 37 + 5) % 512);
    end
  end

  // Compare process: checks both DUTs against the model on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_a) begin
        chk("a_rst_frame_start", 32'(if_a.o_Frame_Start), 32'd0);
        if (rst_q_a) begin
          chk("a_rst_col", 32'(if_a.o_Col), 32'd0);
          chk("a_rst_row", 32'(if_a.o_Row), 32'd0);
          chk("a_rst_hsync", 32'(if_a.o_VGA_HSync), 32'd1);
          chk("a_rst_vsync", 32'(if_a.o_VGA_VSync), 32'd1);
          chk("a_rst_rgb", 32'({if_a.o_VGA_Red, if_a.o_VGA_Grn, if_a.o_VGA_Blu}), 32'd0);
        end
      end else if (started_a) begin
        check_dut("a", t_a, 1, 480, 490, 491, 525, prev_a, if_a.o_Col, if_a.o_Row,
                  if_a.o_Active, if_a.o_Tile_X, if_a.o_Tile_Y, if_a.o_Local_X, if_a.o_Local_Y,
                  if_a.o_Frame_Start, if_a.o_VGA_HSync, if_a.o_VGA_VSync,
                  {if_a.o_VGA_Red, if_a.o_VGA_Grn, if_a.o_VGA_Blu});
        if (t_a == 0) begin hs_cnt_a = 0; hs_first_a = -1; end
        if (t_a < 802 && if_a.o_VGA_HSync === 1'b0) begin
          if (hs_first_a < 0) hs_first_a = t_a;
          hs_cnt_a++;
        end
        if (t_a == 802) begin
          chk("a_hsync_low_clocks", 32'(hs_cnt_a), 32'd96);
          chk("a_hsync_first_low", 32'(hs_first_a), 32'd658);
        end
        if (t_a == 1) chk("a_frame_start_one_clock", 32'(if_a.o_Frame_Start), 32'd0);
        if (t_a == 37) begin
          chk("a_tile_x_col37", 32'(if_a.o_Tile_X), 32'd1);
          chk("a_local_x_col37", 32'(if_a.o_Local_X), 32'd5);
        end
        if (t_a == 39)
          chk("a_rgb_col37", 32'({if_a.o_VGA_Red, if_a.o_VGA_Grn, if_a.o_VGA_Blu}), 32'd37);
        if (t_a == 799) chk("a_col_last", 32'(if_a.o_Col), 32'd799);
        if (t_a == 800) begin
          chk("a_col_wrap", 32'(if_a.o_Col), 32'd0);
          chk("a_row_step", 32'(if_a.o_Row), 32'd1);
        end
      end
      prev_a = if_a.i_Pixel;

      if (rst_b) begin
        chk("b_rst_frame_start", 32'(if_b.o_Frame_Start), 32'd0);
        if (rst_q_b) begin
          chk("b_rst_hsync", 32'(if_b.o_VGA_HSync), 32'd1);
          chk("b_rst_vsync", 32'(if_b.o_VGA_VSync), 32'd1);
          chk("b_rst_rgb", 32'({if_b.o_VGA_Red, if_b.o_VGA_Grn, if_b.o_VGA_Blu}), 32'd0);
        end
      end else if (started_b) begin
        check_dut("b", t_b, 3, 20, 23, 24, 29, prev_b, if_b.o_Col, if_b.o_Row,
                  if_b.o_Active, if_b.o_Tile_X, if_b.o_Tile_Y, if_b.o_Local_X, if_b.o_Local_Y,
                  if_b.o_Frame_Start, if_b.o_VGA_HSync, if_b.o_VGA_VSync,
                  {if_b.o_VGA_Red, if_b.o_VGA_Grn, if_b.o_VGA_Blu});
        if (t_b == 0) begin
          vs_cnt_b = 0; vs_first_b = -1; fs_cnt_b = 0; fs_last_b = -1;
        end
        if (if_b.o_Frame_Start === 1'b1) begin
          if (fs_last_b >= 0) chk("b_frame_period", 32'(t_b - fs_last_b), 32'd23200);
          fs_last_b = t_b;
          fs_cnt_b++;
        end
        if (t_b < 23204 && if_b.o_VGA_VSync === 1'b0) begin
          if (vs_first_b < 0) vs_first_b = t_b;
          vs_cnt_b++;
        end
        if (t_b == 23204) begin
          chk("b_vsync_low_clocks", 32'(vs_cnt_b), 32'd1600);
          chk("b_vsync_first_low", 32'(vs_first_b), 32'd18404);
        end
      end
      prev_b = if_b.i_Pixel;
    end
  end

  // Sequencer: initial reset, a one-clock mid-line reset of A at (300, 2), then a run past B's second frame.
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (1900) @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    repeat (23100) @(posedge clk);
    #2;
    chk("b_frame_pulses", 32'(fs_cnt_b), 32'd2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display back-end. Generates 640x480@60 VGA timing from the 25.175 MHz pixel clock.
- Publishes the current screen coordinate, split into 32x32 tile index and in-tile offset, to the upstream sprite/tile renderers.
- Accepts their registered 9-bit RRR_GGG_BBB pixel and drives the board's 3-bit-per-channel VGA pins.
- Sync and blanking are delayed so they stay aligned with the renderer latency.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIXEL_LATENCY, 1, clocks from coordinate out to matching i_Pixel in; legal range 1..4

Ports:
- i_Clk  in  1  pixel clock
- i_Rst  in  1  synchronous reset, active-high
- o_Col  out  10  current column counter, 0..H_TOTAL-1
- o_Row  out  10  current row counter, 0..V_TOTAL-1
- o_Active  out  1  high when o_Col<H_VISIBLE and o_Row<V_VISIBLE
- o_Tile_X  out  5  o_Col[9:5], tile column 0..19
- o_Tile_Y  out  4  o_Row[8:5], tile row 0..14
- o_Local_X  out  5  o_Col[4:0], pixel within tile
- o_Local_Y  out  5  o_Row[4:0], line within tile
- o_Frame_Start  out  1  one-clock pulse when counters are at (0,0)
- i_Pixel  in  9  renderer colour, {R[2:0],G[2:0],B[2:0]}
- o_VGA_HSync  out  1  horizontal sync, active-low
- o_VGA_VSync  out  1  vertical sync, active-low
- o_VGA_Red  out  3  red channel
- o_VGA_Grn  out  3  green channel
- o_VGA_Blu  out  3  blue channel

Behaviour:
- H_TOTAL = sum of the H_ parameters (800). V_TOTAL = sum of the V_ parameters (525).
- Column counter:
  - increments every clock; wraps H_TOTAL-1 -> 0.
  - on wrap, row counter increments; row wraps V_TOTAL-1 -> 0 on the same clock the column wraps.
- Coordinate group (o_Col, o_Row, o_Active, tile/local fields, o_Frame_Start):
  - combinational from the counters; zero added latency.
  - tile/local fields are don't-care while o_Active=0.
- Raw sync, from counters:
  - hsync_raw low for col in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync_raw low for row in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
- Alignment pipeline:
  - {active, hsync_raw, vsync_raw} pass through a PIXEL_LATENCY-deep shift register, then one output register stage.
  - the output register also captures i_Pixel.
  - coordinate presented in cycle N -> i_Pixel sampled at end of cycle N+PIXEL_LATENCY -> VGA pins valid during cycle N+PIXEL_LATENCY+1.
- Blanking: when the delayed active bit is 0, RGB outputs are forced to 0 regardless of i_Pixel.
- Channel mapping: o_VGA_Red=i_Pixel[8:6], o_VGA_Grn=i_Pixel[5:3], o_VGA_Blu=i_Pixel[2:0].
- Reset, at any time including mid-frame:
  - counters -> (0,0).
  - every delay-line stage -> {active=0, hsync=1, vsync=1}.
  - o_VGA_HSync=1, o_VGA_VSync=1, RGB=0.
  - o_Frame_Start is 0 while i_Rst=1.
  - first clock after reset release presents (0,0) with o_Frame_Start=1.
- No stalls or back-pressure; timing free-runs.
- i_Pixel is ignored outside the sample point defined by the pipeline.

Test Plan:
- Reset hold 5 clocks, release -> o_Col=0, o_Row=0, o_Frame_Start=1 for exactly one clock; HSync=VSync=1 and RGB=0 until pipeline fills.
- Run one line -> o_Col reaches 799 then 0, o_Row 0->1. o_VGA_HSync low for exactly 96 clocks, first low when o_Col was 656 (PIXEL_LATENCY+1 clocks earlier).
- Run full frame -> o_VGA_VSync low exactly 2x800 clocks starting on row 490; o_Frame_Start pulses once per 420000 clocks.
- Drive i_Pixel = o_Col[8:0] delayed 1 clock (model of draw_sprite) -> at pin cycle for col 37, {R,G,B} = 9'd37; col 37 gives o_Tile_X=1, o_Local_X=5.
- Hold i_Pixel=9'h1FF during row 500 and columns 640..799 of any line -> RGB=0 at the pins throughout.
- Assert i_Rst at (col 300, row 200) for 1 clock -> next clock counters (0,0), sync pins high, RGB 0; timing restarts cleanly with a correct first hsync at col 656.
